uart_transmitter: RTL

- Serialises one byte per request onto a UART line: start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits.
- Shares clk_50mhz and the 16x-oversample clock_enable strobe with the UART receiver, so both ends run at the same baud rate.
- Sits between the host-side byte source and the serial_tx pad.
- Simple start/busy/done handshake; one frame in flight at a time, no internal FIFO.

---
 rtl/uart_transmitter.sv | 112 +++++++++++
 1 files changed

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits. Bit timing comes from a shared 16x-style clock_enable
// strobe, so the frame rate tracks the receiver exactly.
module uart_transmitter #(
   parameter int OVERSAMPLE = 16,  // clock_enable ticks per bit, 2..16
   parameter int PARITY_EN  = 0,   // 1 inserts a parity bit after the data
   parameter int PARITY_ODD = 0,   // 0 even, 1 odd
   parameter int STOP_BITS  = 1    // 1 or 2
) (
   input  logic       clk_50mhz,
   input  logic       reset_n,
   input  logic       clock_enable,
   input  logic       tx_start,
   input  logic [7:0] data_in,
   output logic       serial_tx,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int             CW        = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [CW-1:0]  TICK_LAST = CW'(OVERSAMPLE - 1);
   localparam logic [2:0]     STOP_LAST = 3'(STOP_BITS - 1);
   localparam logic           PAR_ODD   = 1'(PARITY_ODD);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t         state;
   logic [CW-1:0]  tick_cnt;
   logic [2:0]     bit_idx;    // data bit index, reused to count stop bits
   logic [7:0]     shift_reg;
   logic           bit_end;

   // Current bit period finishes on this edge.
   assign bit_end = clock_enable && (tick_cnt == TICK_LAST);

   // Frame sequencer; every output is registered so serial_tx cannot glitch.
   always_ff @(posedge clk_50mhz or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         tick_cnt  <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         serial_tx <= 1'b1;
         tx_busy   <= 1'b0;
         tx_done   <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         // Tick counter only runs inside a frame and only on strobes.
         if (state != IDLE && clock_enable)
            tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
         case (state)
            IDLE: begin
               serial_tx <= 1'b1;
               if (tx_start && !tx_busy) begin
                  shift_reg <= data_in;
                  tx_busy   <= 1'b1;
                  state     <= START;
                  tick_cnt  <= '0;
                  bit_idx   <= '0;
                  serial_tx <= 1'b0;   // start bit begins right away
               end
            end
            START: begin
               if (bit_end) begin
                  state     <= DATA;
                  bit_idx   <= '0;
                  serial_tx <= shift_reg[0];
               end
            end
            DATA: begin
               if (bit_end) begin
                  if (bit_idx == 3'd7) begin
                     bit_idx <= '0;
                     if (PARITY_EN != 0) begin
                        state     <= PARITY;
                        serial_tx <= (^shift_reg) ^ PAR_ODD;
                     end else begin
                        state     <= STOP;
                        serial_tx <= 1'b1;
                     end
                  end else begin
                     bit_idx   <= bit_idx + 3'd1;
                     serial_tx <= shift_reg[bit_idx + 3'd1];
                  end
               end
            end
            PARITY: begin
               if (bit_end) begin
                  state     <= STOP;
                  bit_idx   <= '0;
                  serial_tx <= 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  if (bit_idx == STOP_LAST) begin
                     // Last stop tick: release busy and pulse done together.
                     state   <= IDLE;
                     bit_idx <= '0;
                     tx_busy <= 1'b0;
                     tx_done <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
